// File: rtl/msrv32_writeback_unit.sv
// Write-back stage: selects the retiring result, aligns and extends loads,
// and waits for the data-memory acknowledge with a bounded timeout.
module msrv32_writeback_unit #(
    parameter int unsigned LOAD_TIMEOUT = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        valid_in,
    input  logic [4:0]  rd_addr_in,
    input  logic [1:0]  wb_sel_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] csr_data_in,
    input  logic [1:0]  load_size_in,
    input  logic        load_unsigned_in,
    input  logic [1:0]  addr_lsb_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic        dmem_ack_in,
    output logic        stall_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    output logic        wr_en_out,
    output logic        misaligned_load_out,
    output logic        bus_error_out
);

    localparam int unsigned CW = $clog2(LOAD_TIMEOUT) + 1;
    localparam logic [CW-1:0] CntLast = CW'(LOAD_TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    ld_rd_q, ld_rd_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic          ld_uns_q, ld_uns_d;
    logic [1:0]    ld_lsb_q, ld_lsb_d;

    logic          stall_q, stall_d;
    logic          wr_en_q, wr_en_d;
    logic [4:0]    rd_addr_q, rd_addr_d;
    logic [31:0]   rd_q, rd_d;
    logic          mis_q, mis_d;
    logic          berr_q, berr_d;

    logic [31:0]   sel_result;
    logic          misaligned;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    always_comb begin
        unique case (wb_sel_in)
            2'b00:   sel_result = alu_result_in;
            2'b10:   sel_result = pc_plus_4_in;
            2'b11:   sel_result = csr_data_in;
            default: sel_result = alu_result_in;
        endcase
    end

    // Sizes 10 and 11 are both word accesses.
    assign misaligned = ((load_size_in == 2'b01) && addr_lsb_in[0]) ||
                        (load_size_in[1] && (addr_lsb_in != 2'b00));

    assign shifted = ms_riscv32_mp_dmdata_in >> {ld_lsb_q, 3'b000};

    always_comb begin
        unique case (ld_size_q)
            2'b00:   load_data = ld_uns_q ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: begin
                if (ld_lsb_q[1]) begin
                    load_data = ld_uns_q ? {16'b0, ms_riscv32_mp_dmdata_in[31:16]}
                                         : {{16{ms_riscv32_mp_dmdata_in[31]}},
                                            ms_riscv32_mp_dmdata_in[31:16]};
                end else begin
                    load_data = ld_uns_q ? {16'b0, ms_riscv32_mp_dmdata_in[15:0]}
                                         : {{16{ms_riscv32_mp_dmdata_in[15]}},
                                            ms_riscv32_mp_dmdata_in[15:0]};
                end
            end
            default: load_data = ms_riscv32_mp_dmdata_in;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_rd_d   = ld_rd_q;
        ld_size_d = ld_size_q;
        ld_uns_d  = ld_uns_q;
        ld_lsb_d  = ld_lsb_q;
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_d      = rd_q;
        mis_d     = 1'b0;
        berr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    if (wb_sel_in != 2'b01) begin
                        wr_en_d   = (rd_addr_in != 5'd0);
                        rd_addr_d = rd_addr_in;
                        rd_d      = sel_result;
                    end else if (misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        ld_rd_d   = rd_addr_in;
                        ld_size_d = load_size_in;
                        ld_uns_d  = load_unsigned_in;
                        ld_lsb_d  = addr_lsb_in;
                        cnt_d     = '0;
                        state_d   = StLoadWait;
                    end
                end
            end
            StLoadWait: begin
                // Acknowledge takes priority over the timeout.
                if (dmem_ack_in) begin
                    wr_en_d   = (ld_rd_q != 5'd0);
                    rd_addr_d = ld_rd_q;
                    rd_d      = load_data;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (cnt_q == CntLast) begin
                    berr_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        stall_d = (state_d == StLoadWait);
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ld_rd_q   <= '0;
            ld_size_q <= '0;
            ld_uns_q  <= 1'b0;
            ld_lsb_q  <= '0;
            stall_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_q      <= '0;
            mis_q     <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_rd_q   <= ld_rd_d;
            ld_size_q <= ld_size_d;
            ld_uns_q  <= ld_uns_d;
            ld_lsb_q  <= ld_lsb_d;
            stall_q   <= stall_d;
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_q      <= rd_d;
            mis_q     <= mis_d;
            berr_q    <= berr_d;
        end
    end

    assign stall_out           = stall_q;
    assign wr_en_out           = wr_en_q;
    assign rd_addr_out         = rd_addr_q;
    assign rd_out              = rd_q;
    assign misaligned_load_out = mis_q;
    assign bus_error_out       = berr_q;

endmodule

// File: doc/msrv32_writeback_unit.md
MSRV32_WRITEBACK_UNIT -- requirements
Module: msrv32_writeback_unit

Interface
REQ-001 SHALL have parameter LOAD_TIMEOUT, default 16, meaning the maximum number of LOAD_WAIT cycles without an acknowledge before a bus error.
REQ-002 SHALL have port ms_riscv32_mp_clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port valid_in, input, 1 bit: the execute stage presents a retiring instruction.
REQ-005 SHALL have port rd_addr_in, input, 5 bits: destination register index.
REQ-006 SHALL have port wb_sel_in, input, 2 bits: result source; 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-007 SHALL have ports alu_result_in, pc_plus_4_in and csr_data_in, each input, 32 bits: candidate results.
REQ-008 SHALL have port load_size_in, input, 2 bits: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 SHALL have port load_unsigned_in, input, 1 bit: zero-extend (1) or sign-extend (0).
REQ-010 SHALL have port addr_lsb_in, input, 2 bits: byte offset of the load address.
REQ-011 SHALL have port ms_riscv32_mp_dmdata_in, input, 32 bits: data memory read word.
REQ-012 SHALL have port dmem_ack_in, input, 1 bit: the read word is valid this cycle.
REQ-013 SHALL have port stall_out, output, 1 bit: upstream holds its inputs; inputs are ignored while it is high.
REQ-014 SHALL have ports rd_addr_out (output, 5 bits), rd_out (output, 32 bits) and wr_en_out (output, 1 bit): the register-file write port.
REQ-015 SHALL have ports misaligned_load_out and bus_error_out, each output, 1 bit: single-cycle exception pulses.

Function
REQ-016 SHALL implement the states IDLE and LOAD_WAIT; all outputs SHALL be registered.
REQ-017 In IDLE, valid_in=1 with wb_sel_in != 01 SHALL produce, next cycle, wr_en_out=1, rd_addr_out=rd_addr_in and rd_out=the selected source; latency is 1.
REQ-018 Any write with destination index 0 SHALL keep wr_en_out=0, while rd_addr_out and rd_out still update.
REQ-019 wr_en_out SHALL be a one-cycle pulse per instruction; it SHALL be 0 in every cycle that has no accepted write.
REQ-020 In IDLE, a load that is misaligned SHALL pulse misaligned_load_out next cycle, produce no write, and remain in IDLE; misaligned means a half with addr_lsb_in[0]=1, or a word with addr_lsb_in != 00.
REQ-021 In IDLE, an aligned load SHALL capture rd_addr_in, load_size_in, load_unsigned_in and addr_lsb_in, then enter LOAD_WAIT, with stall_out=1 from the next cycle.
REQ-022 dmem_ack_in SHALL be sampled only in LOAD_WAIT; an acknowledge in IDLE is ignored.
REQ-023 In LOAD_WAIT with dmem_ack_in=1, the block SHALL next cycle drive wr_en_out=1 with the aligned data, set stall_out=0, clear the counter, and return to IDLE.
REQ-024 Byte alignment SHALL select bits [8*lsb+7 : 8*lsb]; half alignment SHALL select [31:16] if lsb[1]=1, else [15:0]; the result SHALL be extended per load_unsigned_in to 32 bits.
REQ-025 The timeout counter SHALL increment in each LOAD_WAIT cycle that has no acknowledge.
REQ-026 When the counter equals LOAD_TIMEOUT-1 with no acknowledge, the block SHALL pulse bus_error_out next cycle, produce no write, clear the counter, and return to IDLE.
REQ-027 An acknowledge in the same cycle as the timeout condition SHALL win: write, no bus error.
REQ-028 The counter SHALL be $clog2(LOAD_TIMEOUT)+1 bits wide and SHALL never wrap.

Reset
REQ-029 While ms_riscv32_mp_rst_in=1 at a clock edge, the block SHALL force state=IDLE, counter=0, and all outputs to 0, including stall_out, wr_en_out, rd_out, rd_addr_out and both exception pulses.
REQ-030 A reset during LOAD_WAIT SHALL abandon the load: no write and no bus error follow, even if an acknowledge arrives in the reset cycle.

Verification
REQ-031 ALU write: valid_in=1, wb_sel_in=00, rd_addr_in=5, alu_result_in=30 -> next cycle wr_en_out=1, rd_addr_out=5, rd_out=30; the following cycle wr_en_out=0.
REQ-032 x0 suppression: wb_sel_in=10, rd_addr_in=0, pc_plus_4_in=0x104 -> wr_en_out stays 0.
REQ-033 Signed byte load: rd=10, size=00, lsb=2, unsigned=0; acknowledge after 3 stall cycles with dmdata=0x12F03456 -> stall_out high 3 cycles; then wr_en_out=1, rd_addr_out=10, rd_out=0xFFFFFFF0.
REQ-034 Misaligned load: size=10, lsb=01 -> misaligned_load_out pulses 1 cycle, stall_out=0, no write.
REQ-035 Timeout: aligned load with no acknowledge, LOAD_TIMEOUT=16 -> bus_error_out pulses once after 16 LOAD_WAIT cycles, no write, back in IDLE; a second test gives the acknowledge exactly on cycle 16 -> write occurs and bus_error_out stays 0.
REQ-036 Reset mid-load: assert reset on the second LOAD_WAIT cycle with dmem_ack_in=1 -> all outputs 0 next cycle, no write ever issued.
